// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Shares the register file's single write port between two
//             writeback requesters (A = execute result, B = load unit).
//             Grants one requester per cycle over valid/ready handshakes
//             (round-robin on ties), registers the winning write onto
//             wr_en/wr_reg/wr_data one cycle later, and keeps a per-register
//             pending-write scoreboard (busy) for issue-stage stall logic.
//  Config   : `define WB_ARB_FIXED_PRIO_EN -> B always wins ties, no pointer.
//             Undefined (default)       -> round-robin arbitration.
//  Ports    : clk, aresetn (synchronous, active-low)
//             a_valid/a_ready/a_reg/a_data   requester A handshake + payload
//             b_valid/b_ready/b_reg/b_data   requester B handshake + payload
//             mark_en/mark_reg               reserve a destination register
//             wr_en/wr_reg/wr_data           register file write port
//             busy                           pending-write scoreboard
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int REG_COUNT = 32,
    parameter int REG_W     = 32,
    parameter int REG_IDX_W = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [REG_IDX_W-1:0] a_reg,
    input  logic [REG_W-1:0]     a_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [REG_IDX_W-1:0] b_reg,
    input  logic [REG_W-1:0]     b_data,
    input  logic                 mark_en,
    input  logic [REG_IDX_W-1:0] mark_reg,
    output logic                 wr_en,
    output logic [REG_IDX_W-1:0] wr_reg,
    output logic [REG_W-1:0]     wr_data,
    output logic [REG_COUNT-1:0] busy
);

    logic                 w_grant_a;
    logic                 w_grant_b;
    logic                 w_xfer_a;
    logic                 w_xfer_b;
    logic                 w_xfer;
    logic [REG_IDX_W-1:0] w_sel_reg;
    logic [REG_W-1:0]     w_sel_data;

    logic                 r_wr_en;
    logic [REG_IDX_W-1:0] r_wr_reg;
    logic [REG_W-1:0]     r_wr_data;

`ifndef WB_ARB_FIXED_PRIO_EN
    // 1 = B won the last transfer's arbitration slot... inverted: 1 means B
    // has priority on the next tie (A was granted last).
    logic                 r_prio_b;
`endif

    // ------------------------------------------------------------------
    // Grant selection (combinational)
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (a_valid && b_valid) begin
`ifdef WB_ARB_FIXED_PRIO_EN
            w_grant_b = 1'b1;
`else
            w_grant_a = ~r_prio_b;
            w_grant_b = r_prio_b;
`endif
        end else if (a_valid) begin
            w_grant_a = 1'b1;
        end else if (b_valid) begin
            w_grant_b = 1'b1;
        end
    end

    // Readies are masked while reset is asserted so no handshake completes.
    assign a_ready = aresetn & w_grant_a;
    assign b_ready = aresetn & w_grant_b;

    assign w_xfer_a   = a_valid & a_ready;
    assign w_xfer_b   = b_valid & b_ready;
    assign w_xfer     = w_xfer_a | w_xfer_b;
    assign w_sel_reg  = w_xfer_b ? b_reg  : a_reg;
    assign w_sel_data = w_xfer_b ? b_data : a_data;

    // ------------------------------------------------------------------
    // Output register and arbitration pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_wr_en   <= 1'b0;
            r_wr_reg  <= '0;
            r_wr_data <= '0;
        end else if (w_xfer) begin
            // Writes to register 0 complete the handshake but never reach
            // the register file.
            r_wr_en   <= (w_sel_reg != '0);
            r_wr_reg  <= w_sel_reg;
            r_wr_data <= w_sel_data;
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

`ifndef WB_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_prio_b <= 1'b0;
        end else if (w_xfer) begin
            r_prio_b <= w_xfer_a;
        end
    end
`endif

    assign wr_en   = r_wr_en;
    assign wr_reg  = r_wr_reg;
    assign wr_data = r_wr_data;

    // ------------------------------------------------------------------
    // Pending-write scoreboard. Register 0 is never tracked.
    // A mark and a commit of the same register at one edge: mark wins.
    // ------------------------------------------------------------------
    assign busy[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < REG_COUNT; gi++) begin : g_busy
            localparam logic [REG_IDX_W-1:0] c_idx = REG_IDX_W'(gi);
            logic r_bit;
            logic w_set;
            logic w_clr;

            assign w_set = mark_en & (mark_reg == c_idx);
            assign w_clr = r_wr_en & (r_wr_reg == c_idx);

            always_ff @(posedge clk) begin
                if (!aresetn) begin
                    r_bit <= 1'b0;
                end else if (w_set) begin
                    r_bit <= 1'b1;
                end else if (w_clr) begin
                    r_bit <= 1'b0;
                end
            end

            assign busy[gi] = r_bit;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Directed self-checking bench for regfile_wb_arbiter.
//             Honours `WB_ARB_FIXED_PRIO_EN for tie expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int REG_COUNT = 32;
    localparam int REG_W     = 32;
    localparam int REG_IDX_W = 5;

    logic                 clk;
    logic                 aresetn;
    logic                 a_valid;
    logic                 a_ready;
    logic [REG_IDX_W-1:0] a_reg;
    logic [REG_W-1:0]     a_data;
    logic                 b_valid;
    logic                 b_ready;
    logic [REG_IDX_W-1:0] b_reg;
    logic [REG_W-1:0]     b_data;
    logic                 mark_en;
    logic [REG_IDX_W-1:0] mark_reg;
    logic                 wr_en;
    logic [REG_IDX_W-1:0] wr_reg;
    logic [REG_W-1:0]     wr_data;
    logic [REG_COUNT-1:0] busy;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef WB_ARB_FIXED_PRIO_EN
    localparam bit c_fixed = 1'b1;
`else
    localparam bit c_fixed = 1'b0;
`endif

    regfile_wb_arbiter #(
        .REG_COUNT (REG_COUNT),
        .REG_W     (REG_W),
        .REG_IDX_W (REG_IDX_W)
    ) dut (
        .clk      (clk),
        .aresetn  (aresetn),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_reg    (a_reg),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_reg    (b_reg),
        .b_data   (b_data),
        .mark_en  (mark_en),
        .mark_reg (mark_reg),
        .wr_en    (wr_en),
        .wr_reg   (wr_reg),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are stable afterwards.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_a;

        aresetn  = 1'b0;
        a_valid  = 1'b1;
        b_valid  = 1'b1;
        a_reg    = 5'd1;
        a_data   = 32'h11;
        b_reg    = 5'd2;
        b_data   = 32'h22;
        mark_en  = 1'b0;
        mark_reg = 5'd0;

        // 1. Reset with both requesters valid
        #1;
        chk("rst_a_ready_comb", a_ready, 0);
        chk("rst_b_ready_comb", b_ready, 0);
        tick();
        tick();
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_wr_en",   wr_en, 0);
        chk("rst_busy",    busy, 0);

        // 2. Single transfer from A
        aresetn = 1'b1;
        b_valid = 1'b0;
        a_reg   = 5'd5;
        a_data  = 32'hDEADBEEF;
        #1;
        chk("single_a_ready", a_ready, 1);
        chk("single_b_ready", b_ready, 0);
        tick();
        a_valid = 1'b0;
        chk("single_wr_en",   wr_en, 1);
        chk("single_wr_reg",  wr_reg, 5);
        chk("single_wr_data", wr_data, 32'hDEADBEEF);
        tick();
        chk("single_wr_en_drop", wr_en, 0);

        // 3. Both valid for 4 cycles right after reset
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        a_valid = 1'b1;
        a_reg   = 5'd1;
        a_data  = 32'h11;
        b_valid = 1'b1;
        b_reg   = 5'd2;
        b_data  = 32'h22;
        for (int k = 0; k < 4; k++) begin
            exp_a = c_fixed ? 1'b0 : ((k % 2) == 0);
            #1;
            chk("rr_a_ready", a_ready, exp_a);
            chk("rr_b_ready", b_ready, !exp_a);
            tick();
            chk("rr_wr_en",   wr_en, 1);
            chk("rr_wr_reg",  wr_reg, exp_a ? 5'd1 : 5'd2);
            chk("rr_wr_data", wr_data, exp_a ? 32'h11 : 32'h22);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        chk("rr_idle_wr_en", wr_en, 0);

        // 4. B writes reg 0: accepted, no write, pointer moves to B
        b_valid = 1'b1;
        b_reg   = 5'd0;
        b_data  = 32'h1234;
        #1;
        chk("r0_b_ready", b_ready, 1);
        tick();
        b_valid = 1'b0;
        chk("r0_wr_en", wr_en, 0);
        chk("r0_busy",  busy, 0);
        a_valid = 1'b1;
        a_reg   = 5'd3;
        b_valid = 1'b1;
        b_reg   = 5'd4;
        #1;
        chk("r0_tie_a_ready", a_ready, !c_fixed);
        chk("r0_tie_b_ready", b_ready, c_fixed);
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();

        // 5. Scoreboard set / clear
        mark_en  = 1'b1;
        mark_reg = 5'd7;
        tick();
        mark_en = 1'b0;
        chk("sb_mark7", busy, 32'h0000_0080);
        b_valid = 1'b1;
        b_reg   = 5'd7;
        b_data  = 32'h77;
        tick();
        b_valid = 1'b0;
        chk("sb_commit_wr_en", wr_en, 1);
        chk("sb_busy_before_commit", busy, 32'h0000_0080);
        tick();
        chk("sb_busy_cleared", busy, 0);
        chk("sb_wr_en_low", wr_en, 0);

        // Mark again, then re-mark on the commit edge: set wins
        mark_en  = 1'b1;
        mark_reg = 5'd7;
        tick();
        mark_en = 1'b0;
        b_valid = 1'b1;
        tick();
        b_valid  = 1'b0;
        mark_en  = 1'b1;
        mark_reg = 5'd7;
        tick();
        mark_en = 1'b0;
        chk("sb_set_wins", busy, 32'h0000_0080);

        // Commit 7 while marking 9: both apply
        b_valid = 1'b1;
        tick();
        b_valid  = 1'b0;
        mark_en  = 1'b1;
        mark_reg = 5'd9;
        tick();
        mark_en = 1'b0;
        chk("sb_set_clr_diff", busy, 32'h0000_0200);

        // Mark of reg 0 is ignored
        mark_en  = 1'b1;
        mark_reg = 5'd0;
        tick();
        mark_en = 1'b0;
        chk("sb_mark0", busy, 32'h0000_0200);

        // Committing a non-busy register leaves busy alone
        a_valid = 1'b1;
        a_reg   = 5'd3;
        a_data  = 32'h33;
        tick();
        a_valid = 1'b0;
        chk("sb_nb_wr_reg", wr_reg, 3);
        tick();
        chk("sb_nonbusy_clr", busy, 32'h0000_0200);

        // 6. Transfer then reset: write dropped, scoreboard and pointer cleared
        a_valid = 1'b1;
        a_reg   = 5'd5;
        a_data  = 32'h55;
        tick();
        a_valid = 1'b0;
        aresetn = 1'b0;
        tick();
        chk("rst2_wr_en", wr_en, 0);
        chk("rst2_busy",  busy, 0);
        aresetn = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        chk("rst2_tie_a_ready", a_ready, !c_fixed);
        chk("rst2_tie_b_ready", b_ready, c_fixed);
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
